// File: rtl/multi_timer.sv
// multi_timer: bank of CHANNELS independent down-counting timers behind a
// small register file.
//
// Each channel has a LOAD value, a CTRL register (bit0 enable, bit1
// periodic, bit2 irq_enable), a COUNT register and a prescaler.
// The prescaler divides the clock by 2**TIMER_ADDITIONAL_BITS. Each
// prescaler wrap decrements COUNT by one. When COUNT goes from 1 to 0,
// the channel expires and sets its bit in the shared PENDING register.
//
// Ports:
//   clk               sole clock, rising edge
//   rst               asynchronous active-low reset
//   write             register write strobe
//   address           [1:0] register select, upper bits channel index
//   data_in           write data
//   data_out          combinational read of the addressed register
//   channel_interrupt per-channel pending AND irq_enable (registered)
//   timer_interrupt   OR of channel_interrupt (registered)
module multi_timer #(
    parameter int unsigned CHANNELS              = 4,
    parameter int unsigned TIMER_ADDITIONAL_BITS = 8,
    parameter int unsigned COUNT_WIDTH           = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write,
    input  logic [$clog2(CHANNELS)+1:0]   address,
    input  logic [31:0]                   data_in,
    output logic [31:0]                   data_out,
    output logic [CHANNELS-1:0]           channel_interrupt,
    output logic                          timer_interrupt
);

    localparam int unsigned AW = $clog2(CHANNELS) + 2;
    localparam int unsigned PW = TIMER_ADDITIONAL_BITS;
    localparam int unsigned CW = COUNT_WIDTH;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_PER = 1;
    localparam int unsigned CTRL_IE  = 2;

    typedef enum logic [1:0] {
        REG_LOAD    = 2'd0,
        REG_CTRL    = 2'd1,
        REG_COUNT   = 2'd2,
        REG_PENDING = 2'd3
    } reg_sel_e;

    logic [CW-1:0]       load_q  [CHANNELS];
    logic [CW-1:0]       load_d  [CHANNELS];
    logic [CW-1:0]       count_q [CHANNELS];
    logic [CW-1:0]       count_d [CHANNELS];
    logic [PW-1:0]       presc_q [CHANNELS];
    logic [PW-1:0]       presc_d [CHANNELS];
    logic [2:0]          ctrl_q  [CHANNELS];
    logic [2:0]          ctrl_d  [CHANNELS];
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] irq_q, irq_d;
    logic                tirq_q, tirq_d;

    logic [CHANNELS-1:0] running;
    logic [CHANNELS-1:0] pend_set;
    logic [CHANNELS-1:0] pend_clr;
    logic [CHANNELS-1:0] irq_en_d;

    reg_sel_e            sel;
    logic [AW-1:0]       ch_sel;
    logic                ch_valid;
    logic                unused_data;

    assign sel      = reg_sel_e'(address[1:0]);
    assign ch_sel   = address >> 2;
    assign ch_valid = 32'(ch_sel) < CHANNELS;

    // Upper data_in bits are don't-care for narrow registers.
    assign unused_data = ^data_in;

    // Next-state logic. A LOAD write overrides any advance or expiry
    // of the addressed channel at the same edge.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        running  = '0;
        irq_en_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            load_d[i]  = load_q[i];
            count_d[i] = count_q[i];
            presc_d[i] = presc_q[i];
            ctrl_d[i]  = ctrl_q[i];

            running[i] = ctrl_q[i][CTRL_EN] && (count_q[i] != '0);

            if (running[i]) begin
                presc_d[i] = presc_q[i] + PW'(1);
                if (presc_q[i] == '1) begin
                    if (count_q[i] == CW'(1)) begin
                        pend_set[i] = 1'b1;
                        count_d[i]  = ctrl_q[i][CTRL_PER] ? load_q[i] : '0;
                    end else begin
                        count_d[i] = count_q[i] - CW'(1);
                    end
                end
            end

            if (write && ch_valid && (32'(ch_sel) == i)) begin
                case (sel)
                    REG_LOAD: begin
                        load_d[i]   = data_in[CW-1:0];
                        count_d[i]  = data_in[CW-1:0];
                        presc_d[i]  = '0;
                        pend_set[i] = 1'b0;
                    end
                    REG_CTRL: ctrl_d[i] = data_in[2:0];
                    default: ;
                endcase
            end

            irq_en_d[i] = ctrl_d[i][CTRL_IE];
        end

        if (write && (sel == REG_PENDING)) begin
            pend_clr = data_in[CHANNELS-1:0];
        end

        // Set wins over a coincident write-1-to-clear.
        pending_d = (pending_q & ~pend_clr) | pend_set;
        irq_d     = pending_d & irq_en_d;
        tirq_d    = |irq_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                load_q[i]  <= '0;
                count_q[i] <= '0;
                presc_q[i] <= '0;
                ctrl_q[i]  <= '0;
            end
            pending_q <= '0;
            irq_q     <= '0;
            tirq_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                load_q[i]  <= load_d[i];
                count_q[i] <= count_d[i];
                presc_q[i] <= presc_d[i];
                ctrl_q[i]  <= ctrl_d[i];
            end
            pending_q <= pending_d;
            irq_q     <= irq_d;
            tirq_q    <= tirq_d;
        end
    end

    // Read mux; out-of-range channel indices read as zero.
    always_comb begin
        data_out = '0;
        if (sel == REG_PENDING) begin
            data_out = 32'(pending_q);
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (ch_valid && (32'(ch_sel) == i)) begin
                    case (sel)
                        REG_LOAD:  data_out = 32'(load_q[i]);
                        REG_CTRL:  data_out = 32'(ctrl_q[i]);
                        REG_COUNT: data_out = 32'(count_q[i]);
                        default:   data_out = '0;
                    endcase
                end
            end
        end
    end

    assign channel_interrupt = irq_q;
    assign timer_interrupt   = tirq_q;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer with default parameters.
// Address encoding is {channel[1:0], reg[1:0]}.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic [3:0]  channel_interrupt;
    logic        timer_interrupt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    multi_timer #(
        .CHANNELS              (4),
        .TIMER_ADDITIONAL_BITS (8),
        .COUNT_WIDTH           (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .write             (write),
        .address           (address),
        .data_in           (data_in),
        .data_out          (data_out),
        .channel_interrupt (channel_interrupt),
        .timer_interrupt   (timer_interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_tirq;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic logic [3:0] a(input int ch, input int r);
        return 4'(ch * 4 + r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] ad, input logic [31:0] d);
        @(negedge clk);
        write   = 1'b1;
        address = ad;
        data_in = d;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] ad, input logic [31:0] exp);
        address = ad;
        #1;
        chk(name, data_out, exp);
    endtask

    // idx < 0 watches timer_interrupt; returns cycle stamp or -1 on timeout
    task automatic wait_irq(input int idx, input int budget, output int t);
        t = -1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            if ((idx < 0) ? timer_interrupt : channel_interrupt[idx]) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b0;
        address = a(0, 0);
        #1;
        chk("reset_dout", data_out, 32'h0);
        chk("reset_tirq", 32'(timer_interrupt), 32'h0);
        chk("reset_chirq", 32'(channel_interrupt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t, t0, rel;
        int tl [4];
        int tk [4];
        int any_irq;

        vecs[0]  = '{1'b0, a(0, 0), 32'h0,         32'h0,         1'b0};
        vecs[1]  = '{1'b1, a(0, 0), 32'h12345678,  32'h12345678,  1'b0};
        vecs[2]  = '{1'b1, a(0, 1), 32'hFFFFFFFA,  32'h2,         1'b0};
        vecs[3]  = '{1'b0, a(0, 2), 32'h0,         32'h12345678,  1'b0};
        vecs[4]  = '{1'b1, a(0, 2), 32'h5,         32'h12345678,  1'b0};
        vecs[5]  = '{1'b1, a(3, 0), 32'h7,         32'h7,         1'b0};
        vecs[6]  = '{1'b0, a(1, 0), 32'h0,         32'h0,         1'b0};
        vecs[7]  = '{1'b1, a(1, 1), 32'h4,         32'h4,         1'b0};
        vecs[8]  = '{1'b0, a(0, 3), 32'h0,         32'h0,         1'b0};
        vecs[9]  = '{1'b0, a(3, 3), 32'h0,         32'h0,         1'b0};
        vecs[10] = '{1'b1, a(0, 0), 32'h0,         32'h0,         1'b0};
        vecs[11] = '{1'b0, a(0, 2), 32'h0,         32'h0,         1'b0};
        vecs[12] = '{1'b1, a(3, 1), 32'h0,         32'h0,         1'b0};

        // initial reset, checked while asserted
        #2;
        chk("init_dout", data_out, 32'h0);
        chk("init_tirq", 32'(timer_interrupt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // register access vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            write   = vecs[i].wr;
            address = vecs[i].addr;
            data_in = vecs[i].din;
            @(posedge clk);
            #1;
            write = 1'b0;
            chk($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_dout);
            chk($sformatf("vec%0d_tirq", i), 32'(timer_interrupt), 32'(vecs[i].exp_tirq));
        end

        // one-shot: ch0 CTRL=5, LOAD=3 -> expiry 768 edges later
        do_reset();
        wr(a(0, 1), 32'h5);
        wr(a(0, 0), 32'd3);
        t0 = cyc;
        wait_irq(-1, 2000, t);
        rel = (t < 0) ? -1 : t - t0;
        chk("oneshot_latency", 32'(rel), 32'd768);
        chk("oneshot_chirq", 32'(channel_interrupt), 32'h1);
        repeat (300) begin
            @(posedge clk);
            #1;
        end
        chk("oneshot_hold", 32'(timer_interrupt), 32'h1);
        rd_chk("oneshot_count0", a(0, 2), 32'h0);
        rd_chk("oneshot_pending", a(0, 3), 32'h1);

        // periodic ch2 LOAD=2, W1C each period, absolute timing
        do_reset();
        wr(a(2, 1), 32'h7);
        wr(a(2, 0), 32'd2);
        t0 = cyc;
        for (int p = 0; p < 5; p++) begin
            wait_irq(2, 700, t);
            rel = (t < 0) ? -1 : t - t0;
            chk($sformatf("periodic_exp%0d", p), 32'(rel), 32'(512 * (p + 1)));
            wr(a(0, 3), 32'h4);
            rd_chk($sformatf("periodic_clr%0d", p), a(0, 3), 32'h0);
        end

        // pause: ch1 LOAD=4, disabled at +300 for 100 edges
        do_reset();
        wr(a(1, 1), 32'h5);
        wr(a(1, 0), 32'd4);
        t0 = cyc;
        wait_until(t0 + 299);
        wr(a(1, 1), 32'h4);
        wait_until(t0 + 350);
        rd_chk("pause_frozen_count", a(1, 2), 32'd3);
        wait_until(t0 + 399);
        wr(a(1, 1), 32'h5);
        wait_irq(1, 1000, t);
        rel = (t < 0) ? -1 : t - t0;
        chk("pause_latency", 32'(rel), 32'd1124);

        // W1C coinciding with expiry; mask without clear
        do_reset();
        wr(a(0, 1), 32'h7);
        wr(a(0, 0), 32'd1);
        t0 = cyc;
        wait_until(t0 + 255);
        wr(a(0, 3), 32'h1);
        rd_chk("race_pending_set", a(0, 3), 32'h1);
        chk("race_chirq", 32'(channel_interrupt), 32'h1);
        wr(a(0, 3), 32'h1);
        rd_chk("race_later_clr", a(0, 3), 32'h0);
        wait_irq(0, 400, t);
        rel = (t < 0) ? -1 : t - t0;
        chk("race_next_period", 32'(rel), 32'd512);
        wr(a(0, 1), 32'h3);
        chk("mask_chirq", 32'(channel_interrupt), 32'h0);
        rd_chk("mask_keeps_pending", a(0, 3), 32'h1);
        wr(a(0, 1), 32'h7);
        chk("unmask_tirq", 32'(timer_interrupt), 32'h1);
        wr(a(0, 0), 32'h0);
        rd_chk("load_keeps_pending", a(0, 3), 32'h1);

        // four channels, LOAD 1..4
        do_reset();
        for (int k = 0; k < 4; k++) wr(a(k, 1), 32'h5);
        for (int k = 0; k < 4; k++) begin
            wr(a(k, 0), 32'(k + 1));
            tl[k] = cyc;
            tk[k] = -1;
        end
        for (int n = 0; n < 1200; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (tk[k] < 0 && channel_interrupt[k]) tk[k] = cyc - tl[k];
            end
            if (tk[3] >= 0) break;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("multi_ch%0d", k), 32'(tk[k]), 32'(256 * (k + 1)));
        end

        // asynchronous reset mid-count
        do_reset();
        wr(a(0, 1), 32'h7);
        wr(a(0, 0), 32'd1);
        wr(a(1, 1), 32'h5);
        wr(a(1, 0), 32'd3);
        repeat (300) begin
            @(posedge clk);
            #1;
        end
        chk("prerst_tirq", 32'(timer_interrupt), 32'h1);
        address = a(1, 2);
        #3;
        rst = 1'b0;
        #1;
        chk("async_tirq", 32'(timer_interrupt), 32'h0);
        chk("async_chirq", 32'(channel_interrupt), 32'h0);
        chk("async_count", data_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        any_irq = 0;
        repeat (10000) begin
            @(posedge clk);
            #1;
            if (timer_interrupt || (channel_interrupt != '0)) any_irq = 1;
        end
        chk("postrst_no_irq", 32'(any_irq), 32'h0);
        rd_chk("postrst_count", a(1, 2), 32'h0);
        rd_chk("postrst_ctrl", a(0, 1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
